flu_fifo_plus: RTL and testbench

Synchronous FLU FIFO that buffers the word stream produced by the FLU transformer together with its per-packet HEADER and CHANNEL sideband. Sits directly downstream of the transformer output and decouples it from consumer backpressure. Every accepted FLU word, with its SOP/EOP flags and positions, is stored and replayed in order with first-word-fall-through timing.

---
 rtl/flu_fifo_plus.sv | 102 ++++++++++
 tb/tb_flu_fifo_plus.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/flu_fifo_plus.sv
// rtl/flu_fifo_plus.sv - first-word-fall-through FIFO for FLU words with header/channel sideband
// Optional STATUS occupancy port enabled by defining FLU_FIFO_PLUS_STATUS_EN.
module flu_fifo_plus #(
    parameter int DATA_WIDTH    = 256,
    parameter int SOP_POS_WIDTH = 2,
    parameter int HEADER_WIDTH  = 8,
    parameter int CHANNEL_WIDTH = 2,
    parameter int ITEMS         = 16,
    localparam int EOP_POS_WIDTH     = $clog2(DATA_WIDTH / 8),
    localparam int SOP_POS_WIDTH_FIX = (SOP_POS_WIDTH < 1) ? 1 : SOP_POS_WIDTH,
    localparam int CNT_WIDTH         = $clog2(ITEMS) + 1
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic [DATA_WIDTH-1:0]        RX_DATA,
    input  logic [SOP_POS_WIDTH_FIX-1:0] RX_SOP_POS,
    input  logic [EOP_POS_WIDTH-1:0]     RX_EOP_POS,
    input  logic                         RX_SOP,
    input  logic                         RX_EOP,
    input  logic [HEADER_WIDTH-1:0]      RX_HEADER,
    input  logic [CHANNEL_WIDTH-1:0]     RX_CHANNEL,
    input  logic                         RX_SRC_RDY,
    output logic                         RX_DST_RDY,
    output logic [DATA_WIDTH-1:0]        TX_DATA,
    output logic [SOP_POS_WIDTH_FIX-1:0] TX_SOP_POS,
    output logic [EOP_POS_WIDTH-1:0]     TX_EOP_POS,
    output logic                         TX_SOP,
    output logic                         TX_EOP,
    output logic [HEADER_WIDTH-1:0]      TX_HEADER,
    output logic [CHANNEL_WIDTH-1:0]     TX_CHANNEL,
    output logic                         TX_SRC_RDY,
    input  logic                         TX_DST_RDY,
    output logic                         FULL,
    output logic                         EMPTY
`ifdef FLU_FIFO_PLUS_STATUS_EN
    ,
    output logic [CNT_WIDTH-1:0]         STATUS
`endif
);

    localparam int PTR_WIDTH  = $clog2(ITEMS);
    localparam int WORD_WIDTH = DATA_WIDTH + SOP_POS_WIDTH_FIX + EOP_POS_WIDTH + 2
                              + HEADER_WIDTH + CHANNEL_WIDTH;

    logic [WORD_WIDTH-1:0] mem [ITEMS];
    logic [PTR_WIDTH-1:0]  wr_ptr;
    logic [PTR_WIDTH-1:0]  rd_ptr;
    logic [CNT_WIDTH-1:0]  cnt;
    logic [CNT_WIDTH-1:0]  cnt_next;
    logic                  rx_rdy_q;
    logic                  push;
    logic                  pop;
    logic                  head_sop;
    logic                  head_eop;

    assign push = RX_SRC_RDY & rx_rdy_q;
    assign pop  = TX_SRC_RDY & TX_DST_RDY;

    always_comb begin
        cnt_next = cnt;
        case ({push, pop})
            2'b10:   cnt_next = cnt + CNT_WIDTH'(1);
            2'b01:   cnt_next = cnt - CNT_WIDTH'(1);
            default: cnt_next = cnt;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            rx_rdy_q <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_WIDTH'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_WIDTH'(1);
            cnt      <= cnt_next;
            // Ready is registered, so a full FIFO cannot take a word in the cycle it pops.
            rx_rdy_q <= (cnt_next != CNT_WIDTH'(ITEMS));
        end
    end

    // Storage is deliberately left out of reset; stale entries are unreachable via the pointers.
    always_ff @(posedge CLK) begin
        if (push)
            mem[wr_ptr] <= {RX_DATA, RX_SOP_POS, RX_EOP_POS, RX_SOP, RX_EOP, RX_HEADER, RX_CHANNEL};
    end

    assign {TX_DATA, TX_SOP_POS, TX_EOP_POS, head_sop, head_eop, TX_HEADER, TX_CHANNEL} = mem[rd_ptr];

    assign EMPTY      = (cnt == '0);
    assign FULL       = (cnt == CNT_WIDTH'(ITEMS));
    assign TX_SRC_RDY = ~EMPTY;
    assign TX_SOP     = head_sop & TX_SRC_RDY;
    assign TX_EOP     = head_eop & TX_SRC_RDY;
    assign RX_DST_RDY = rx_rdy_q;

`ifdef FLU_FIFO_PLUS_STATUS_EN
    assign STATUS = cnt;
`endif

endmodule

// File: tb/tb_flu_fifo_plus.sv
// tb/tb_flu_fifo_plus.sv - randomized queue-model bench for flu_fifo_plus
module tb_flu_fifo_plus;

    localparam int DW    = 256;
    localparam int SPW   = 2;
    localparam int EPW   = 5;
    localparam int HW    = 8;
    localparam int CW    = 2;
    localparam int ITEMS = 16;
    localparam int STW   = 5;

    typedef struct {
        logic [DW-1:0]  data;
        logic [SPW-1:0] sop_pos;
        logic [EPW-1:0] eop_pos;
        logic           sop;
        logic           eop;
        logic [HW-1:0]  header;
        logic [CW-1:0]  channel;
    } word_t;

    logic           CLK = 1'b0;
    logic           RESET = 1'b1;
    logic [DW-1:0]  RX_DATA = '0;
    logic [SPW-1:0] RX_SOP_POS = '0;
    logic [EPW-1:0] RX_EOP_POS = '0;
    logic           RX_SOP = 1'b0;
    logic           RX_EOP = 1'b0;
    logic [HW-1:0]  RX_HEADER = '0;
    logic [CW-1:0]  RX_CHANNEL = '0;
    logic           RX_SRC_RDY = 1'b0;
    logic           RX_DST_RDY;
    logic [DW-1:0]  TX_DATA;
    logic [SPW-1:0] TX_SOP_POS;
    logic [EPW-1:0] TX_EOP_POS;
    logic           TX_SOP;
    logic           TX_EOP;
    logic [HW-1:0]  TX_HEADER;
    logic [CW-1:0]  TX_CHANNEL;
    logic           TX_SRC_RDY;
    logic           TX_DST_RDY = 1'b0;
    logic           FULL;
    logic           EMPTY;
`ifdef FLU_FIFO_PLUS_STATUS_EN
    logic [STW-1:0] STATUS;
`endif

    flu_fifo_plus dut (
        .CLK(CLK), .RESET(RESET),
        .RX_DATA(RX_DATA), .RX_SOP_POS(RX_SOP_POS), .RX_EOP_POS(RX_EOP_POS),
        .RX_SOP(RX_SOP), .RX_EOP(RX_EOP), .RX_HEADER(RX_HEADER), .RX_CHANNEL(RX_CHANNEL),
        .RX_SRC_RDY(RX_SRC_RDY), .RX_DST_RDY(RX_DST_RDY),
        .TX_DATA(TX_DATA), .TX_SOP_POS(TX_SOP_POS), .TX_EOP_POS(TX_EOP_POS),
        .TX_SOP(TX_SOP), .TX_EOP(TX_EOP), .TX_HEADER(TX_HEADER), .TX_CHANNEL(TX_CHANNEL),
        .TX_SRC_RDY(TX_SRC_RDY), .TX_DST_RDY(TX_DST_RDY),
        .FULL(FULL), .EMPTY(EMPTY)
`ifdef FLU_FIFO_PLUS_STATUS_EN
        , .STATUS(STATUS)
`endif
    );

    always #5 CLK = ~CLK;

    int    n_cmp = 0;
    int    n_bad = 0;
    int    n_push = 0;
    bit    chk_en = 1'b0;
    bit    armed = 1'b0;
    word_t q[$];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: a plain queue; a word is accepted only when the previous edge left room.
    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            q.delete();
            armed = 1'b0;
        end else begin
            bit do_push, do_pop;
            do_push = RX_SRC_RDY && armed && (q.size() < ITEMS);
            do_pop  = (q.size() > 0) && TX_DST_RDY;
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                word_t w;
                w.data = RX_DATA; w.sop_pos = RX_SOP_POS; w.eop_pos = RX_EOP_POS;
                w.sop = RX_SOP; w.eop = RX_EOP; w.header = RX_HEADER; w.channel = RX_CHANNEL;
                q.push_back(w);
                n_push++;
            end
            armed = 1'b1;
        end
    end

    always @(negedge CLK) begin
        if (chk_en && !RESET) begin
            check("rx_dst_rdy", DW'(RX_DST_RDY), DW'(armed && q.size() < ITEMS));
            check("empty", DW'(EMPTY), DW'(q.size() == 0));
            check("full", DW'(FULL), DW'(q.size() == ITEMS));
            check("tx_src_rdy", DW'(TX_SRC_RDY), DW'(q.size() != 0));
`ifdef FLU_FIFO_PLUS_STATUS_EN
            check("status", DW'(STATUS), DW'(q.size()));
`endif
            if (q.size() == 0) begin
                check("tx_sop_gated", DW'(TX_SOP), '0);
                check("tx_eop_gated", DW'(TX_EOP), '0);
            end else begin
                check("tx_data", TX_DATA, q[0].data);
                check("tx_sop_pos", DW'(TX_SOP_POS), DW'(q[0].sop_pos));
                check("tx_eop_pos", DW'(TX_EOP_POS), DW'(q[0].eop_pos));
                check("tx_sop", DW'(TX_SOP), DW'(q[0].sop));
                check("tx_eop", DW'(TX_EOP), DW'(q[0].eop));
                if (q[0].sop) begin
                    check("tx_header", DW'(TX_HEADER), DW'(q[0].header));
                    check("tx_channel", DW'(TX_CHANNEL), DW'(q[0].channel));
                end
            end
        end
    end

    function automatic word_t rand_word();
        word_t w;
        for (int i = 0; i < DW / 32; i++) w.data[i*32 +: 32] = $urandom;
        w.sop_pos = SPW'($urandom); w.eop_pos = EPW'($urandom);
        w.sop = 1'($urandom); w.eop = 1'($urandom);
        w.header = HW'($urandom); w.channel = CW'($urandom);
        return w;
    endfunction

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic step(input word_t w, input logic v, input logic tr);
        RX_DATA = w.data; RX_SOP_POS = w.sop_pos; RX_EOP_POS = w.eop_pos;
        RX_SOP = w.sop; RX_EOP = w.eop; RX_HEADER = w.header; RX_CHANNEL = w.channel;
        RX_SRC_RDY = v; TX_DST_RDY = tr;
        @(posedge CLK);
        @(negedge CLK);
        #1;
    endtask

    task automatic drain();
        int guard = 0;
        while (q.size() != 0 && guard < 40) begin
            step(rand_word(), 1'b0, 1'b1);
            guard++;
        end
        check("drain_bound", DW'(q.size()), '0);
    endtask

    initial begin
        word_t w;
        int    guard;
        @(negedge CLK); #1;
        check("reset_rx_dst_rdy", DW'(RX_DST_RDY), '0);
        check("reset_empty", DW'(EMPTY), DW'(1));
        check("reset_full", DW'(FULL), '0);
        check("reset_tx_src_rdy", DW'(TX_SRC_RDY), '0);
        RESET = 1'b0;
        @(negedge CLK); #1;
        check("release_rx_dst_rdy", DW'(RX_DST_RDY), DW'(1));
        chk_en = 1'b1;

        // Fill to the brim with the consumer stalled, then offer a 17th word.
        for (int i = 0; i < ITEMS; i++) step(rand_word(), 1'b1, 1'b0);
        check("fill_full", DW'(FULL), DW'(1));
        check("fill_rx_dst_rdy", DW'(RX_DST_RDY), '0);
        check("model_depth", DW'(q.size()), DW'(16));
        step(rand_word(), 1'b1, 1'b0);
        check("no_17th", DW'(n_push), DW'(16));
        step(rand_word(), 1'b1, 1'b1);
        check("full_pop_no_push", DW'(q.size()), DW'(15));
        check("full_pop_ready", DW'(RX_DST_RDY), DW'(1));
        check("full_pop_not_full", DW'(FULL), '0);
        drain();

        for (int i = 0; i < 3; i++) begin
            w = rand_word();
            w.sop_pos = 2'd1; w.eop_pos = 5'd17; w.header = 8'hA5; w.channel = 2'd2;
            w.sop = (i == 0); w.eop = (i == 2);
            step(w, 1'b1, 1'b1);
            if (i == 0) begin
                check("pkt_first_valid", DW'(TX_SRC_RDY), DW'(1));
                check("pkt_first_sop", DW'(TX_SOP), DW'(1));
                check("pkt_header", DW'(TX_HEADER), DW'(8'hA5));
                check("pkt_channel", DW'(TX_CHANNEL), DW'(2));
            end
        end
        drain();

        w = rand_word();
        w.sop = 1'b1; w.eop = 1'b1; w.header = 8'h3C;
        step(w, 1'b1, 1'b0);
        check("se_header", DW'(TX_HEADER), DW'(8'h3C));
        check("se_sop", DW'(TX_SOP), DW'(1));
        check("se_eop", DW'(TX_EOP), DW'(1));
        drain();

        guard = 0;
        n_push = 0;
        while (n_push < 1000 && guard < 6000) begin
            step(rand_word(), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0));
            guard++;
        end
        check("random_words_pushed", DW'(n_push >= 1000), DW'(1));
        drain();

        for (int i = 0; i < 5; i++) begin
            w = rand_word();
            w.sop = (i == 0); w.eop = 1'b0;
            step(w, 1'b1, 1'b0);
        end
        RESET = 1'b1;
        #1;
        check("async_rx_dst_rdy", DW'(RX_DST_RDY), '0);
        check("async_tx_src_rdy", DW'(TX_SRC_RDY), '0);
        check("async_tx_sop", DW'(TX_SOP), '0);
        check("async_tx_eop", DW'(TX_EOP), '0);
        check("async_empty", DW'(EMPTY), DW'(1));
        check("async_full", DW'(FULL), '0);
        RX_SRC_RDY = 1'b0;
        @(posedge CLK); @(negedge CLK); #1;
        RESET = 1'b0;
        @(negedge CLK); #1;
        check("post_reset_ready", DW'(RX_DST_RDY), DW'(1));
        check("post_reset_empty", DW'(EMPTY), DW'(1));
        for (int i = 0; i < 60; i++)
            step(rand_word(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        drain();

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
